prim_assembler: RTL and testbench

Primitive-assembly stage sitting directly downstream of the vertex transform stage: consumes the transformed vertex stream (`O_VOut`/`O_ColorOut` plus opcode), groups vertices between `OP_BEGINPRIMITIVE` and `OP_ENDPRIMITIVE` into triangles (list or strip), and hands complete triangles to the rasterizer through a 2-deep valid/ready buffer. Back-pressure to the vertex stage is a single stall line.

---
 rtl/prim_assembler_pkg.sv | 30 +++
 rtl/prim_assembler_tri_fifo.sv | 50 +++++
 rtl/prim_assembler.sv | 129 ++++++++++++
 tb/tb_prim_assembler.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/prim_assembler_pkg.sv
// Shared opcodes, widths, mode encodings and the triangle record for primitive assembly.
// Opcode values must match the vertex-stage encoding.
package prim_assembler_pkg;

  localparam int OPCODE_WIDTH = 8;
  localparam int VREG_WIDTH   = 64;
  localparam int TRI_WIDTH    = 160;

  localparam logic [OPCODE_WIDTH-1:0] OP_BEGINPRIMITIVE = 8'h30;
  localparam logic [OPCODE_WIDTH-1:0] OP_ENDPRIMITIVE   = 8'h31;
  localparam logic [OPCODE_WIDTH-1:0] OP_SETVERTEX      = 8'h32;

  localparam logic MODE_LIST  = 1'b0;
  localparam logic MODE_STRIP = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LIST  = 2'd1,
    ST_STRIP = 2'd2
  } pa_state_e;

  // Each vertex position is {y[15:0], x[15:0]}; color is that of the provoking vertex.
  typedef struct packed {
    logic [31:0] v2;
    logic [31:0] v1;
    logic [31:0] v0;
    logic [63:0] color;
  } tri_t;

endpackage

// File: rtl/prim_assembler_tri_fifo.sv
// Generic FIFO, negedge-clocked, with combinational head (zero when empty).
// Latency: a push is visible at the head right after the writing edge; a full FIFO refuses a push even on a popping edge.
module tri_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 160
) (
  input  logic             core_clk,
  input  logic             arst_n,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_dat
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      occ;
  logic             do_push;
  logic             do_pop;

  assign full     = (occ == (AW+1)'(DEPTH));
  assign empty    = (occ == '0);
  assign do_push  = push_vld && !full;
  assign do_pop   = pop_rdy && !empty;
  assign head_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(negedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      occ <= occ + 1'b1;
      else if (do_pop && !do_push) occ <= occ - 1'b1;
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(negedge core_clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/prim_assembler.sv
// Groups transformed vertices into list/strip triangles and queues them for the rasterizer.
// Latency: triangle valid right after the completing vertex edge; O_Stall (buffer full) drops incoming vertices.
module prim_assembler
  import prim_assembler_pkg::*;
#(
  parameter int TRI_FIFO_DEPTH = 2,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                    I_CLOCK,
  input  logic                    I_RESET_N,
  input  logic                    I_LOCK,
  input  logic [OPCODE_WIDTH-1:0] I_Opcode,
  input  logic [VREG_WIDTH-1:0]   I_VIn,
  input  logic [VREG_WIDTH-1:0]   I_ColorIn,
  input  logic                    I_Mode,
  output logic                    O_Stall,
  output logic                    O_TriValid,
  input  logic                    I_TriReady,
  output logic [95:0]             O_TriVerts,
  output logic [63:0]             O_TriColor,
  output logic [CNT_WIDTH-1:0]    O_TriCount,
  output logic                    O_Overflow
);

  pa_state_e      state_q, state_d;
  logic [1:0]     vcnt_q, vcnt_d;
  logic           parity_q, parity_d;
  logic [31:0]    w0_q, w0_d, w1_q, w1_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic           ovf_q;
  logic           fifo_full, fifo_empty;
  logic           emit;
  tri_t           tri_d, tri_head;
  logic [31:0]    new_pos;
  logic           is_begin, is_end, vtx_in, vtx_take;
  logic           unused_vin;

  assign new_pos    = I_VIn[47:16];
  assign unused_vin = ^{I_VIn[63:48], I_VIn[15:0]};
  assign is_begin   = I_LOCK && (I_Opcode == OP_BEGINPRIMITIVE);
  assign is_end     = I_LOCK && (I_Opcode == OP_ENDPRIMITIVE);
  assign vtx_in     = I_LOCK && (I_Opcode == OP_SETVERTEX);
  assign vtx_take   = vtx_in && (state_q != ST_IDLE) && !fifo_full;

  always_comb begin
    state_d  = state_q;
    vcnt_d   = vcnt_q;
    parity_d = parity_q;
    w0_d     = w0_q;
    w1_d     = w1_q;
    emit     = 1'b0;
    tri_d    = '0;
    if (is_begin) begin
      state_d  = (I_Mode == MODE_STRIP) ? ST_STRIP : ST_LIST;
      vcnt_d   = 2'd0;
      parity_d = 1'b0;
    end else if (is_end) begin
      state_d  = ST_IDLE;
      vcnt_d   = 2'd0;
      parity_d = 1'b0;
    end else if (vtx_take) begin
      if (vcnt_q == 2'd0) begin
        w0_d   = new_pos;
        vcnt_d = 2'd1;
      end else if (vcnt_q == 2'd1) begin
        w1_d   = new_pos;
        vcnt_d = 2'd2;
      end else begin
        emit        = 1'b1;
        tri_d.v2    = new_pos;
        tri_d.color = I_ColorIn;
        if (state_q == ST_STRIP) begin
          // Odd strip triangles swap the first two vertices to keep winding consistent.
          tri_d.v1 = parity_q ? w0_q : w1_q;
          tri_d.v0 = parity_q ? w1_q : w0_q;
          w0_d     = w1_q;
          w1_d     = new_pos;
          parity_d = ~parity_q;
        end else begin
          tri_d.v1 = w1_q;
          tri_d.v0 = w0_q;
          vcnt_d   = 2'd0;
        end
      end
    end
  end

  always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state_q  <= ST_IDLE;
      vcnt_q   <= '0;
      parity_q <= 1'b0;
      w0_q     <= '0;
      w1_q     <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      vcnt_q   <= vcnt_d;
      parity_q <= parity_d;
      w0_q     <= w0_d;
      w1_q     <= w1_d;
      if (emit)                 cnt_q <= cnt_q + 1'b1;
      if (vtx_in && fifo_full)  ovf_q <= 1'b1;
    end
  end

  tri_fifo #(
    .DEPTH(TRI_FIFO_DEPTH),
    .WIDTH(TRI_WIDTH)
  ) u_tri_fifo (
    .core_clk (I_CLOCK),
    .arst_n   (I_RESET_N),
    .push_vld (emit),
    .push_dat (tri_d),
    .pop_rdy  (I_TriReady),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_dat (tri_head)
  );

  assign O_Stall    = fifo_full;
  assign O_TriValid = !fifo_empty;
  assign O_TriVerts = {tri_head.v2, tri_head.v1, tri_head.v0};
  assign O_TriColor = tri_head.color;
  assign O_TriCount = cnt_q;
  assign O_Overflow = ovf_q;

endmodule

// File: tb/tb_prim_assembler.sv
// Bench for prim_assembler: vector table plus scoreboard of expected triangles, with
// hand sequences for async reset and counter wrap.
module tb_prim_assembler;
  import prim_assembler_pkg::*;

  logic                    I_CLOCK, I_RESET_N, I_LOCK, I_Mode, I_TriReady;
  logic [OPCODE_WIDTH-1:0] I_Opcode;
  logic [VREG_WIDTH-1:0]   I_VIn, I_ColorIn;
  logic                    O_Stall, O_TriValid, O_Overflow;
  logic [95:0]             O_TriVerts;
  logic [63:0]             O_TriColor;
  logic [15:0]             O_TriCount;

  prim_assembler #(.TRI_FIFO_DEPTH(2), .CNT_WIDTH(16)) dut (
    .I_CLOCK(I_CLOCK), .I_RESET_N(I_RESET_N), .I_LOCK(I_LOCK), .I_Opcode(I_Opcode),
    .I_VIn(I_VIn), .I_ColorIn(I_ColorIn), .I_Mode(I_Mode), .O_Stall(O_Stall),
    .O_TriValid(O_TriValid), .I_TriReady(I_TriReady), .O_TriVerts(O_TriVerts),
    .O_TriColor(O_TriColor), .O_TriCount(O_TriCount), .O_Overflow(O_Overflow)
  );

  initial I_CLOCK = 1'b0;
  always #5 I_CLOCK = ~I_CLOCK;

  localparam logic [7:0] OPB = OP_BEGINPRIMITIVE;
  localparam logic [7:0] OPE = OP_ENDPRIMITIVE;
  localparam logic [7:0] OPV = OP_SETVERTEX;
  localparam logic [7:0] OPN = 8'h00;

  typedef struct packed {
    logic [7:0]  op;
    logic        lock;
    logic        mode;
    logic [15:0] x, y;
    logic [63:0] col;
    logic        rdy;
    logic        emit;
    logic [95:0] verts;
    logic        stall;
    logic        ovf;
    logic [15:0] cnt;
  } vec_t;

  typedef struct packed {
    logic [95:0] verts;
    logic [63:0] color;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   step_id = 0;

  function automatic vec_t mk(input logic [7:0] op, input logic lock, input logic mode,
                              input logic [15:0] x, input logic [15:0] y, input logic [63:0] col,
                              input logic rdy, input logic emit, input logic [95:0] verts,
                              input logic stall, input logic ovf, input logic [15:0] cnt);
    vec_t v;
    v.op = op; v.lock = lock; v.mode = mode; v.x = x; v.y = y; v.col = col; v.rdy = rdy;
    v.emit = emit; v.verts = verts; v.stall = stall; v.ovf = ovf; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (step %0d): got %0h, want %0h", nm, step_id, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    @(posedge I_CLOCK); #1;
    step_id++;
    I_LOCK     = v.lock;
    I_Opcode   = v.op;
    I_Mode     = v.mode;
    I_VIn      = {16'hDEAD, v.y, v.x, 16'hBEEF};
    I_ColorIn  = v.col;
    I_TriReady = v.rdy;
    if (v.emit) begin
      e.verts = v.verts;
      e.color = v.col;
      sb.push_back(e);
    end
    @(negedge I_CLOCK); #1;
    chk("stall", O_Stall, v.stall);
    chk("overflow", O_Overflow, v.ovf);
    chk("tri_count", O_TriCount, v.cnt);
  endtask

  // Checks the head against the scoreboard whenever it is about to be popped.
  initial begin
    exp_t e;
    forever begin
      @(posedge I_CLOCK); #2;
      if (I_RESET_N && O_TriValid && I_TriReady) begin
        if (sb.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_tri (step %0d): got %0h, want no triangle", step_id, O_TriVerts);
        end else begin
          e = sb.pop_front();
          chk("tri_verts", O_TriVerts, e.verts);
          chk("tri_color", O_TriColor, e.color);
        end
      end
    end
  end

  initial begin
    exp_t e;
    I_RESET_N = 1'b0; I_LOCK = 1'b0; I_Opcode = '0; I_Mode = 1'b0;
    I_VIn = '0; I_ColorIn = '0; I_TriReady = 1'b0;
    #3;
    chk("rst_valid", O_TriValid, 0);
    chk("rst_stall", O_Stall, 0);
    chk("rst_count", O_TriCount, 0);
    chk("rst_ovf", O_Overflow, 0);
    chk("rst_verts", O_TriVerts, 0);
    chk("rst_color", O_TriColor, 0);
    repeat (2) @(posedge I_CLOCK);
    #1 I_RESET_N = 1'b1;

    // list
    tbl.push_back(mk(OPB,1,0, 0,0, 0,    1,0,0, 0,0,0));
    tbl.push_back(mk(OPV,1,0, 1,2, 'hAA, 1,0,0, 0,0,0));
    tbl.push_back(mk(OPV,1,0, 3,4, 'hAA, 1,0,0, 0,0,0));
    tbl.push_back(mk(OPV,1,0, 5,6, 'hAA, 1,1,96'h00060005_00040003_00020001, 0,0,1));
    tbl.push_back(mk(OPE,1,0, 0,0, 0,    1,0,0, 0,0,1));
    tbl.push_back(mk(8'h07,1,0, 0,0, 0,  1,0,0, 0,0,1));
    tbl.push_back(mk(OPV,1,0, 7,8, 'hBB, 1,0,0, 0,0,1));
    // strip
    tbl.push_back(mk(OPB,1,1, 0,0, 0, 1,0,0, 0,0,1));
    tbl.push_back(mk(OPV,1,1, 'h0A,'h0B, 1, 1,0,0, 0,0,1));
    tbl.push_back(mk(OPV,1,1, 'h0C,'h0D, 2, 1,0,0, 0,0,1));
    tbl.push_back(mk(OPV,1,1, 'h0E,'h0F, 3, 1,1,96'h000F000E_000D000C_000B000A, 0,0,2));
    tbl.push_back(mk(OPV,0,1, 'h50,'h51, 9, 1,0,0, 0,0,2));
    tbl.push_back(mk(OPV,1,1, 'h10,'h11, 4, 1,1,96'h00110010_000D000C_000F000E, 0,0,3));
    tbl.push_back(mk(OPV,1,1, 'h12,'h13, 5, 1,1,96'h00130012_00110010_000F000E, 0,0,4));
    tbl.push_back(mk(OPE,1,0, 0,0, 0, 1,0,0, 0,0,4));
    // partial primitive discarded at END
    tbl.push_back(mk(OPB,1,0, 0,0, 0, 1,0,0, 0,0,4));
    tbl.push_back(mk(OPV,1,0, 'h20,'h21, 6, 1,0,0, 0,0,4));
    tbl.push_back(mk(OPV,1,0, 'h22,'h23, 6, 1,0,0, 0,0,4));
    tbl.push_back(mk(OPE,1,0, 0,0, 0, 1,0,0, 0,0,4));
    tbl.push_back(mk(OPB,1,0, 0,0, 0, 1,0,0, 0,0,4));
    tbl.push_back(mk(OPV,1,0, 'h30,'h31, 6, 1,0,0, 0,0,4));
    tbl.push_back(mk(OPV,1,0, 'h32,'h33, 6, 1,0,0, 0,0,4));
    tbl.push_back(mk(OPV,1,0, 'h34,'h35, 6, 1,1,96'h00350034_00330032_00310030, 0,0,5));
    tbl.push_back(mk(OPE,1,0, 0,0, 0, 1,0,0, 0,0,5));
    // restart mid-primitive with a new mode
    tbl.push_back(mk(OPB,1,1, 0,0, 0, 1,0,0, 0,0,5));
    tbl.push_back(mk(OPV,1,1, 'h40,'h41, 7, 1,0,0, 0,0,5));
    tbl.push_back(mk(OPV,1,1, 'h42,'h43, 7, 1,0,0, 0,0,5));
    tbl.push_back(mk(OPB,1,0, 0,0, 0, 1,0,0, 0,0,5));
    tbl.push_back(mk(OPV,1,0, 'h44,'h45, 7, 1,0,0, 0,0,5));
    tbl.push_back(mk(OPV,1,0, 'h46,'h47, 7, 1,0,0, 0,0,5));
    tbl.push_back(mk(OPV,1,0, 'h48,'h49, 7, 1,1,96'h00490048_00470046_00450044, 0,0,6));
    tbl.push_back(mk(OPV,1,0, 'h4A,'h4B, 7, 1,0,0, 0,0,6));
    tbl.push_back(mk(OPE,1,0, 0,0, 0, 1,0,0, 0,0,6));
    // back-pressure: two triangles fill the buffer, later vertices dropped
    tbl.push_back(mk(OPB,1,0, 0,0, 0, 0,0,0, 0,0,6));
    tbl.push_back(mk(OPV,1,0, 'h60,'h61, 8, 0,0,0, 0,0,6));
    tbl.push_back(mk(OPV,1,0, 'h62,'h63, 8, 0,0,0, 0,0,6));
    tbl.push_back(mk(OPV,1,0, 'h64,'h65, 8, 0,1,96'h00650064_00630062_00610060, 0,0,7));
    tbl.push_back(mk(OPV,1,0, 'h66,'h67, 9, 0,0,0, 0,0,7));
    tbl.push_back(mk(OPV,1,0, 'h68,'h69, 9, 0,0,0, 0,0,7));
    tbl.push_back(mk(OPV,1,0, 'h6A,'h6B, 9, 0,1,96'h006B006A_00690068_00670066, 1,0,8));
    tbl.push_back(mk(OPV,1,0, 'h6C,'h6D, 9, 0,0,0, 1,1,8));
    tbl.push_back(mk(OPV,1,0, 'h6E,'h6F, 9, 0,0,0, 1,1,8));
    tbl.push_back(mk(OPV,1,0, 'h70,'h71, 9, 0,0,0, 1,1,8));
    tbl.push_back(mk(OPN,0,0, 0,0, 0, 1,0,0, 0,1,8));
    tbl.push_back(mk(OPN,0,0, 0,0, 0, 1,0,0, 0,1,8));
    tbl.push_back(mk(OPV,1,0, 'h72,'h73, 'hA, 1,0,0, 0,1,8));
    tbl.push_back(mk(OPV,1,0, 'h74,'h75, 'hA, 1,0,0, 0,1,8));
    tbl.push_back(mk(OPV,1,0, 'h76,'h77, 'hA, 1,1,96'h00770076_00750074_00730072, 0,1,9));
    tbl.push_back(mk(OPE,1,0, 0,0, 0, 1,0,0, 0,1,9));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // async reset mid-strip with two buffered triangles
    apply(mk(OPB,1,1, 0,0, 0, 0,0,0, 0,1,9));
    apply(mk(OPV,1,1, 'h80,'h81, 1, 0,0,0, 0,1,9));
    apply(mk(OPV,1,1, 'h82,'h83, 1, 0,0,0, 0,1,9));
    apply(mk(OPV,1,1, 'h84,'h85, 1, 0,1,96'h00850084_00830082_00810080, 0,1,10));
    apply(mk(OPV,1,1, 'h86,'h87, 1, 0,1,96'h00870086_00830082_00850084, 1,1,11));
    @(posedge I_CLOCK); #3;
    I_RESET_N = 1'b0; I_LOCK = 1'b0;
    #1;
    chk("arst_valid", O_TriValid, 0);
    chk("arst_count", O_TriCount, 0);
    chk("arst_ovf", O_Overflow, 0);
    chk("arst_stall", O_Stall, 0);
    sb.delete();
    repeat (2) @(posedge I_CLOCK);
    #1 I_RESET_N = 1'b1;
    // vertices without BEGIN after reset are ignored
    apply(mk(OPV,1,0, 1,1, 1, 1,0,0, 0,0,0));
    apply(mk(OPV,1,0, 2,2, 1, 1,0,0, 0,0,0));
    apply(mk(OPV,1,0, 3,3, 1, 1,0,0, 0,0,0));

    // counter wrap: 65535 identical strip triangles, then one more
    apply(mk(OPB,1,1, 0,0, 0, 1,0,0, 0,0,0));
    e.verts = {3{32'h00020001}};
    e.color = 64'h3;
    for (int i = 0; i < 65537; i++) begin
      @(posedge I_CLOCK); #1;
      I_LOCK = 1'b1; I_Opcode = OPV; I_TriReady = 1'b1;
      I_VIn = {16'h5A5A, 16'h0002, 16'h0001, 16'hA5A5};
      I_ColorIn = 64'h3;
      if (i >= 2) sb.push_back(e);
    end
    @(negedge I_CLOCK); #1;
    chk("cnt_ffff", O_TriCount, 16'hFFFF);
    apply(mk(OPV,1,1, 1,2, 3, 1,1,{3{32'h00020001}}, 0,0,16'h0000));
    apply(mk(OPE,1,0, 0,0, 0, 1,0,0, 0,0,16'h0000));
    repeat (3) apply(mk(OPN,0,0, 0,0, 0, 1,0,0, 0,0,16'h0000));
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
